sram_2w2r_bank_resp: RTL and testbench

Physical-bank responder for the two-write/two-read SRAM interface that the 1R2W algorithm wrappers drive: writes on ports A/B with per-bit enables, reads on ports C/D. One instance models one physical bank of NUMSROW x PHYWDTH. It returns read data after a fixed SRAM_DELAY and clears its array after reset before asserting ready. It sits below the algorithm wrapper in block-level benches and in the FPGA-emulation build, in place of a compiled macro.

---
 rtl/sram_bank_pkg.sv | 19 +
 rtl/sram_rd_pipe.sv | 32 +++
 rtl/sram_2w2r_bank_resp.sv | 147 ++++++++++++++
 tb/tb_sram_2w2r_bank_resp.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bank_pkg.sv
// Shared types, limits and parameter checking for the 2W2R SRAM bank responder.
package sram_bank_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bankState_t;

  localparam int MAX_SRAM_DELAY = 8;

  // Rows must be addressable with bitsRow bits and the read latency must fit the pipe.
  function automatic bit paramsLegal(input int phyWdth, input int numsRow,
                                     input int bitsRow, input int sramDelay);
    return (phyWdth > 0) && (bitsRow > 0) && (bitsRow < 31) && (numsRow > 1) &&
           (numsRow <= (1 << bitsRow)) &&
           (sramDelay >= 1) && (sramDelay <= MAX_SRAM_DELAY);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Fixed-latency read-data pipe; the output only changes when a valid read reaches the end.
module sram_rd_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  input  logic [WIDTH-1:0] inData,
  output logic [WIDTH-1:0] outData
);

  logic [DEPTH-1:0] validPipe;
  logic [WIDTH-1:0] dataPipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validPipe <= '0;
      for (int i = 0; i < DEPTH; i++) dataPipe[i] <= '0;
      outData <= '0;
    end else begin
      validPipe[0] <= inValid;
      dataPipe[0]  <= inData;
      for (int i = 1; i < DEPTH; i++) begin
        validPipe[i] <= validPipe[i-1];
        dataPipe[i]  <= dataPipe[i-1];
      end
      if (validPipe[DEPTH-1]) outData <= dataPipe[DEPTH-1];
    end
  end

endmodule

// File: rtl/sram_2w2r_bank_resp.sv
// One physical bank behind a 2-write/2-read SRAM interface; clears itself after reset.
// Define SRAM_COLL_CHK_EN to enable the registered coll_err checker and X on colliding reads.
module sram_2w2r_bank_resp
  import sram_bank_pkg::*;
#(
  parameter int PHYWDTH    = 128,
  parameter int NUMSROW    = 4096,
  parameter int BITSROW    = 12,
  parameter int SRAM_DELAY = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               t1_writeA,
  input  logic [BITSROW-1:0] t1_addrA,
  input  logic [PHYWDTH-1:0] t1_dinA,
  input  logic [PHYWDTH-1:0] t1_bwA,
  input  logic               t1_writeB,
  input  logic [BITSROW-1:0] t1_addrB,
  input  logic [PHYWDTH-1:0] t1_dinB,
  input  logic [PHYWDTH-1:0] t1_bwB,
  input  logic               t1_readC,
  input  logic [BITSROW-1:0] t1_addrC,
  output logic [PHYWDTH-1:0] t1_doutC,
  input  logic               t1_readD,
  input  logic [BITSROW-1:0] t1_addrD,
  output logic [PHYWDTH-1:0] t1_doutD,
  output logic               coll_err
);

  localparam int IDXW = (NUMSROW > 1) ? $clog2(NUMSROW) : 1;
  localparam logic [BITSROW:0] ROW_LIMIT = (BITSROW+1)'(NUMSROW);
  localparam logic [IDXW-1:0]  LAST_ROW  = IDXW'(NUMSROW - 1);

  if (!paramsLegal(PHYWDTH, NUMSROW, BITSROW, SRAM_DELAY)) begin : gBadParams
    $error("sram_2w2r_bank_resp: illegal parameter combination");
  end

  bankState_t        state, stateNext;
  logic [IDXW-1:0]   initCnt, initCntNext;
  logic [PHYWDTH-1:0] mem [NUMSROW];

  logic              runNow;
  logic              inRangeA, inRangeB, inRangeC, inRangeD;
  logic [IDXW-1:0]   idxA, idxB, idxC, idxD;
  logic              wrA, wrB, rdC, rdD;
  logic [PHYWDTH-1:0] mergeA, baseB, mergeB;
  logic [PHYWDTH-1:0] rdDataC, rdDataD, pipeInC, pipeInD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      initCnt <= '0;
    end else begin
      state   <= stateNext;
      initCnt <= initCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    initCntNext = initCnt;
    ready       = 1'b0;
    case (state)
      INIT: begin
        initCntNext = initCnt + IDXW'(1);
        if (initCnt == LAST_ROW) begin
          stateNext   = RUN;
          initCntNext = '0;
        end
      end
      RUN: ready = 1'b1;
      default: stateNext = INIT;
    endcase
  end

  assign runNow   = (state == RUN);
  assign inRangeA = {1'b0, t1_addrA} < ROW_LIMIT;
  assign inRangeB = {1'b0, t1_addrB} < ROW_LIMIT;
  assign inRangeC = {1'b0, t1_addrC} < ROW_LIMIT;
  assign inRangeD = {1'b0, t1_addrD} < ROW_LIMIT;
  assign idxA     = t1_addrA[IDXW-1:0];
  assign idxB     = t1_addrB[IDXW-1:0];
  assign idxC     = t1_addrC[IDXW-1:0];
  assign idxD     = t1_addrD[IDXW-1:0];

  assign wrA = runNow & t1_writeA & inRangeA;
  assign wrB = runNow & t1_writeB & inRangeB;
  assign rdC = runNow & t1_readC;
  assign rdD = runNow & t1_readD;

  // B's merge starts from A's result when both hit the same row, so B wins on shared bits.
  assign mergeA = (mem[idxA] & ~t1_bwA) | (t1_dinA & t1_bwA);
  assign baseB  = (wrA && idxA == idxB) ? mergeA : mem[idxB];
  assign mergeB = (baseB & ~t1_bwB) | (t1_dinB & t1_bwB);

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[initCnt] <= '0;
    end else begin
      if (wrA) mem[idxA] <= mergeA;
      if (wrB) mem[idxB] <= mergeB;
    end
  end

  assign rdDataC = inRangeC ? mem[idxC] : '0;
  assign rdDataD = inRangeD ? mem[idxD] : '0;

`ifdef SRAM_COLL_CHK_EN
  logic abOverlap, badAddr, rwCollC, rwCollD;

  assign abOverlap = wrA & wrB & (idxA == idxB) & (|(t1_bwA & t1_bwB));
  assign badAddr   = runNow & ((t1_writeA & ~inRangeA) | (t1_writeB & ~inRangeB) |
                               (t1_readC & ~inRangeC) | (t1_readD & ~inRangeD));
  assign rwCollC   = rdC & inRangeC & ((wrA & (idxA == idxC)) | (wrB & (idxB == idxC)));
  assign rwCollD   = rdD & inRangeD & ((wrA & (idxA == idxD)) | (wrB & (idxB == idxD)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_err <= 1'b0;
    else     coll_err <= abOverlap | badAddr | rwCollC | rwCollD;
  end

  assign pipeInC = rwCollC ? {PHYWDTH{1'bx}} : rdDataC;
  assign pipeInD = rwCollD ? {PHYWDTH{1'bx}} : rdDataD;
`else
  assign coll_err = 1'b0;
  assign pipeInC  = rdDataC;
  assign pipeInD  = rdDataD;
`endif

  sram_rd_pipe #(.DEPTH(SRAM_DELAY), .WIDTH(PHYWDTH)) uPipeC (
    .clk     (clk),
    .rst     (rst),
    .inValid (rdC),
    .inData  (pipeInC),
    .outData (t1_doutC)
  );

  sram_rd_pipe #(.DEPTH(SRAM_DELAY), .WIDTH(PHYWDTH)) uPipeD (
    .clk     (clk),
    .rst     (rst),
    .inValid (rdD),
    .inData  (pipeInD),
    .outData (t1_doutD)
  );

endmodule

// File: tb/tb_sram_2w2r_bank_resp.sv
// Directed scoreboard bench for sram_2w2r_bank_resp (16 rows, 64-bit rows, SRAM_DELAY=2).
module tb_sram_2w2r_bank_resp;

  localparam int W = 64;
  localparam int N = 16;
  localparam int B = 5;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready;
  logic         t1_writeA, t1_writeB, t1_readC, t1_readD;
  logic [B-1:0] t1_addrA, t1_addrB, t1_addrC, t1_addrD;
  logic [W-1:0] t1_dinA, t1_bwA, t1_dinB, t1_bwB;
  logic [W-1:0] t1_doutC, t1_doutD;
  logic         coll_err;

  always #5 clk = ~clk;

  sram_2w2r_bank_resp #(.PHYWDTH(W), .NUMSROW(N), .BITSROW(B), .SRAM_DELAY(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .t1_writeA (t1_writeA),
    .t1_addrA  (t1_addrA),
    .t1_dinA   (t1_dinA),
    .t1_bwA    (t1_bwA),
    .t1_writeB (t1_writeB),
    .t1_addrB  (t1_addrB),
    .t1_dinB   (t1_dinB),
    .t1_bwB    (t1_bwB),
    .t1_readC  (t1_readC),
    .t1_addrC  (t1_addrC),
    .t1_doutC  (t1_doutC),
    .t1_readD  (t1_readD),
    .t1_addrD  (t1_addrD),
    .t1_doutD  (t1_doutD),
    .coll_err  (coll_err)
  );

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } rdExp_t;

  rdExp_t       qC[$];
  rdExp_t       qD[$];
  logic [W-1:0] model [N];
  logic [W-1:0] lastC, lastD;
  logic         collNext, collExp;
  bit           tbRun;
  int           cyc;
  int           checks;
  int           failures;

  task automatic checkEq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit inR(input logic [B-1:0] a);
    return int'(a) < N;
  endfunction

  // Completed reads update the expected hold value; otherwise the output must not move.
  task automatic checkOutput();
    rdExp_t e;
    if (qC.size() > 0 && qC[0].due == cyc) begin
      e = qC.pop_front();
      lastC = e.data;
    end
    if (qD.size() > 0 && qD[0].due == cyc) begin
      e = qD.pop_front();
      lastD = e.data;
    end
    checkEq($sformatf("doutC@%0d", cyc), t1_doutC, lastC);
    checkEq($sformatf("doutD@%0d", cyc), t1_doutD, lastD);
    checkEq($sformatf("coll_err@%0d", cyc), W'(coll_err), W'(collExp));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    collExp  = collNext;
    collNext = 1'b0;
    #1;
    t1_writeA = 1'b0;
    t1_writeB = 1'b0;
    t1_readC  = 1'b0;
    t1_readD  = 1'b0;
    checkOutput();
  endtask

  task automatic applyStimulus();
    logic [W-1:0] expC, expD;
`ifdef SRAM_COLL_CHK_EN
    logic collC, collD, ab, bad;
`endif
    if (tbRun) begin
      expC = inR(t1_addrC) ? model[t1_addrC[3:0]] : '0;
      expD = inR(t1_addrD) ? model[t1_addrD[3:0]] : '0;
`ifdef SRAM_COLL_CHK_EN
      collC = t1_readC && inR(t1_addrC) &&
              ((t1_writeA && inR(t1_addrA) && t1_addrA == t1_addrC) ||
               (t1_writeB && inR(t1_addrB) && t1_addrB == t1_addrC));
      collD = t1_readD && inR(t1_addrD) &&
              ((t1_writeA && inR(t1_addrA) && t1_addrA == t1_addrD) ||
               (t1_writeB && inR(t1_addrB) && t1_addrB == t1_addrD));
      ab    = t1_writeA && t1_writeB && inR(t1_addrA) && inR(t1_addrB) &&
              t1_addrA == t1_addrB && ((t1_bwA & t1_bwB) != '0);
      bad   = (t1_writeA && !inR(t1_addrA)) || (t1_writeB && !inR(t1_addrB)) ||
              (t1_readC && !inR(t1_addrC)) || (t1_readD && !inR(t1_addrD));
      if (collC) expC = 'x;
      if (collD) expD = 'x;
      collNext = collC || collD || ab || bad;
`endif
      if (t1_readC) qC.push_back('{due: cyc + 1 + D, data: expC});
      if (t1_readD) qD.push_back('{due: cyc + 1 + D, data: expD});
      if (t1_writeA && inR(t1_addrA))
        model[t1_addrA[3:0]] = (model[t1_addrA[3:0]] & ~t1_bwA) | (t1_dinA & t1_bwA);
      if (t1_writeB && inR(t1_addrB))
        model[t1_addrB[3:0]] = (model[t1_addrB[3:0]] & ~t1_bwB) | (t1_dinB & t1_bwB);
    end
    tick();
  endtask

  // Asserts rst between edges and checks that outputs clear immediately.
  task automatic resetAsync();
    rst = 1'b1;
    qC.delete();
    qD.delete();
    lastC    = '0;
    lastD    = '0;
    tbRun    = 1'b0;
    collNext = 1'b0;
    collExp  = 1'b0;
    for (int r = 0; r < N; r++) model[r] = '0;
    #1;
    checkEq("rstReady", W'(ready), '0);
    checkEq("rstDoutC", t1_doutC, '0);
    checkEq("rstDoutD", t1_doutD, '0);
    checkEq("rstColl", W'(coll_err), '0);
  endtask

  task automatic waitReady();
    for (int k = 1; k <= N; k++) begin
      tick();
      checkEq($sformatf("ready@init%0d", k), W'(ready), W'(k == N));
    end
    tbRun = 1'b1;
  endtask

  task automatic drain();
    repeat (D + 2) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    t1_writeA = 0; t1_writeB = 0; t1_readC = 0; t1_readD = 0;
    t1_addrA = '0; t1_addrB = '0; t1_addrC = '0; t1_addrD = '0;
    t1_dinA = '0; t1_dinB = '0; t1_bwA = '0; t1_bwB = '0;

    resetAsync();
    tick(); tick();
    rst = 1'b0;
    waitReady();

    // Every row reads back zero after INIT, both ports at full rate.
    for (int i = 0; i < N; i++) begin
      t1_readC = 1; t1_addrC = B'(i);
      t1_readD = 1; t1_addrD = B'(N - 1 - i);
      applyStimulus();
    end
    drain();

    // Full-row write then read on the next cycle.
    t1_writeA = 1; t1_addrA = 5'd3; t1_dinA = {8{8'hAA}}; t1_bwA = '1;
    applyStimulus();
    t1_readC = 1; t1_addrC = 5'd3;
    applyStimulus();
    drain();

    // A and B on the same row with overlapping enables: B wins.
    t1_writeA = 1; t1_addrA = 5'd5; t1_dinA = '1; t1_bwA = {{32{1'b0}}, {32{1'b1}}};
    t1_writeB = 1; t1_addrB = 5'd5; t1_dinB = '0; t1_bwB = '1;
    applyStimulus();
    t1_readC = 1; t1_addrC = 5'd5;
    applyStimulus();
    drain();

    // Read-old-data on a same-cycle write, new data one cycle later.
    t1_writeA = 1; t1_addrA = 5'd7; t1_dinA = {8{8'h11}}; t1_bwA = '1;
    applyStimulus();
    t1_writeB = 1; t1_addrB = 5'd7; t1_dinB = {8{8'h22}}; t1_bwB = '1;
    t1_readD = 1; t1_addrD = 5'd7;
    applyStimulus();
    t1_readD = 1; t1_addrD = 5'd7;
    applyStimulus();
    drain();

    // Fill rows with distinct data (partial enables on B), then stream reads over all rows.
    for (int i = 0; i < N / 2; i++) begin
      t1_writeA = 1; t1_addrA = B'(i);     t1_dinA = {$urandom, $urandom}; t1_bwA = '1;
      t1_writeB = 1; t1_addrB = B'(i + 8); t1_dinB = {$urandom, $urandom};
      t1_bwB = {$urandom, $urandom};
      applyStimulus();
    end
    for (int i = 0; i < N; i++) begin
      t1_readC = 1; t1_addrC = B'(i);
      t1_readD = 1; t1_addrD = B'(N - 1 - i);
      applyStimulus();
    end
    drain();

    // Out-of-range writes are dropped and out-of-range reads return zero.
    t1_writeA = 1; t1_addrA = 5'd16; t1_dinA = '1; t1_bwA = '1;
    t1_writeB = 1; t1_addrB = 5'd20; t1_dinB = '1; t1_bwB = '1;
    t1_readC = 1; t1_addrC = 5'd31;
    t1_readD = 1; t1_addrD = 5'd17;
    applyStimulus();
    t1_readC = 1; t1_addrC = 5'd0;
    t1_readD = 1; t1_addrD = 5'd4;
    applyStimulus();
    drain();

    // Reset mid-RUN with two reads in flight on each port.
    t1_readC = 1; t1_addrC = 5'd3;
    t1_readD = 1; t1_addrD = 5'd7;
    applyStimulus();
    drain();
    t1_readC = 1; t1_addrC = 5'd10;
    t1_readD = 1; t1_addrD = 5'd11;
    applyStimulus();
    t1_readC = 1; t1_addrC = 5'd12;
    t1_readD = 1; t1_addrD = 5'd13;
    applyStimulus();
    resetAsync();
    tick(); tick();
    rst = 1'b0;
    waitReady();
    t1_readC = 1; t1_addrC = 5'd3;
    t1_readD = 1; t1_addrD = 5'd12;
    applyStimulus();
    drain();

    // Reset mid-INIT at row 9 restarts the clear from row 0.
    t1_writeA = 1; t1_addrA = 5'd14; t1_dinA = {8{8'h5C}}; t1_bwA = '1;
    applyStimulus();
    resetAsync();
    tick();
    rst = 1'b0;
    repeat (9) tick();
    checkEq("readyMidInit", W'(ready), '0);
    resetAsync();
    tick();
    rst = 1'b0;
    waitReady();
    t1_readC = 1; t1_addrC = 5'd14;
    applyStimulus();
    t1_writeA = 1; t1_addrA = 5'd2; t1_dinA = 64'h0123_4567_89AB_CDEF; t1_bwA = '1;
    applyStimulus();
    t1_readD = 1; t1_addrD = 5'd2;
    applyStimulus();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
